spi_minion_ctrl: RTL

SPI_MINION_CTRL -- requirements
Module: spi_minion_ctrl

---
 rtl/spi_minion_pkg.sv | 21 ++
 rtl/spi_minion_shiftreg.sv | 66 ++++++
 rtl/spi_minion_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_minion_pkg.sv
// Shared definitions for the SPI minion controller.
//
// Contents:
//   SPI_MINION_MAX_NBITS - largest supported frame width.
//   spi_minion_state_e   - controller FSM state encoding.
//   sat_inc8             - saturating 8-bit increment for the status counters.
package spi_minion_pkg;

  localparam int unsigned SPI_MINION_MAX_NBITS = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StWaitCs = 2'd2
  } spi_minion_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/spi_minion_shiftreg.sv
// Frame shift register and bit counter for the SPI minion.
//
// A load seeds the register with the transmit word and clears the counter.
// Each shift moves the register left by one, pulling the MOSI bit into the
// LSB and advancing the counter. The counter stops at NBITS and never wraps.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   load        - seed register with load_val, counter := 0
//   load_val    - transmit word to seed
//   shift       - shift one MOSI bit in
//   mosi        - serial input bit
//   shreg_msb   - current MSB (drives MISO)
//   shift_word  - register value after the shift in progress (completed word)
//   count       - number of bits shifted so far in this frame
//   done        - this shift is the final bit of the frame
module spi_minion_shiftreg #(
  parameter int unsigned NBITS = 8,
  localparam int unsigned CntW = $clog2(NBITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [NBITS-1:0] load_val,
  input  logic             shift,
  input  logic             mosi,
  output logic             shreg_msb,
  output logic [NBITS-1:0] shift_word,
  output logic [CntW-1:0]  count,
  output logic             done
);

  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             at_end;

  assign at_end     = (count_q == CntW'(NBITS));
  assign shift_word = {shreg_q[NBITS-2:0], mosi};
  assign done       = shift & ~load & (count_q == CntW'(NBITS - 1));

  always_comb begin
    shreg_d = shreg_q;
    count_d = count_q;
    if (load) begin
      shreg_d = load_val;
      count_d = '0;
    end else if (shift && !at_end) begin
      shreg_d = shift_word;
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      count_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      count_q <= count_d;
    end
  end

  assign shreg_msb = shreg_q[NBITS-1];
  assign count     = count_q;

endmodule

// File: rtl/spi_minion_ctrl.sv
// SPI minion (mode 0) frame controller.
//
// Receives NBITS-wide frames MSB first on MOSI while shifting a word taken
// from the pull stream out on MISO. Completed receive words are offered on a
// one-entry push buffer; a frame that completes while the buffer is still
// occupied (and not being drained) is dropped. A chip-select release before
// the last bit aborts the frame without a push.
//
// Optional build macro SPI_MINION_CTRL_STATUS_EN adds saturating abort and
// overrun counters as outputs.
//
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   cs                 - synchronized chip-select level (active low)
//   cs_negedge         - one-cycle pulse at frame start
//   cs_posedge         - one-cycle pulse at frame end
//   sclk_posedge       - one-cycle pulse at each SCLK rising (sample) edge
//   mosi               - synchronized MOSI level
//   miso               - serial data to master
//   pull_val/rdy/msg   - transmit word stream from fabric
//   push_val/rdy/msg   - received word stream to fabric
//   abort_count        - (status build) aborted frames, saturating
//   overrun_count      - (status build) dropped frames, saturating
module spi_minion_ctrl
  import spi_minion_pkg::*;
#(
  parameter int unsigned NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             cs_negedge,
  input  logic             cs_posedge,
  input  logic             sclk_posedge,
  input  logic             mosi,
  output logic             miso,
  input  logic             pull_val,
  output logic             pull_rdy,
  input  logic [NBITS-1:0] pull_msg,
  output logic             push_val,
  input  logic             push_rdy,
  output logic [NBITS-1:0] push_msg
`ifdef SPI_MINION_CTRL_STATUS_EN
  ,
  output logic [7:0]       abort_count,
  output logic [7:0]       overrun_count
`endif
);

  localparam int unsigned CntW = $clog2(NBITS + 1);

  spi_minion_state_e state_q, state_d;

  logic             sr_load;
  logic             sr_shift;
  logic             sr_msb;
  logic [NBITS-1:0] sr_word;
  logic [CntW-1:0]  sr_count;
  logic             sr_done;
  logic [NBITS-1:0] load_val;

  logic             push_val_q, push_val_d;
  logic [NBITS-1:0] push_msg_q, push_msg_d;
  logic             push_drain;
  logic             overrun;
  logic             abort;

  // An empty pull stream at frame start transmits all zeros.
  assign load_val = pull_val ? pull_msg : '0;

  spi_minion_shiftreg #(
    .NBITS(NBITS)
  ) u_shiftreg (
    .clk        (clk),
    .reset      (reset),
    .load       (sr_load),
    .load_val   (load_val),
    .shift      (sr_shift),
    .mosi       (mosi),
    .shreg_msb  (sr_msb),
    .shift_word (sr_word),
    .count      (sr_count),
    .done       (sr_done)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cs_negedge) state_d = StShift;
      end
      StShift: begin
        // A final bit coincident with CS release still completes the frame.
        if (sr_done) begin
          state_d = cs_posedge ? StIdle : StWaitCs;
        end else if (cs_posedge) begin
          state_d = StIdle;
        end
      end
      StWaitCs: begin
        if (cs_posedge) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    pull_rdy = 1'b0;
    miso     = 1'b0;
    unique case (state_q)
      StIdle: begin
        sr_load  = cs_negedge;
        pull_rdy = cs_negedge & ~reset;
      end
      StShift: begin
        sr_shift = sclk_posedge & (sr_count < CntW'(NBITS));
        miso     = sr_msb & ~cs & ~reset;
      end
      StWaitCs: begin
        sr_shift = 1'b0;
      end
      default: begin
        sr_load = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Push buffer
  // ---------------------------------------------------------------------------
  assign push_drain = push_val_q & push_rdy;
  assign overrun    = sr_done & push_val_q & ~push_rdy;
  assign abort      = (state_q == StShift) & cs_posedge & ~sr_done;

  always_comb begin
    push_val_d = push_val_q;
    push_msg_d = push_msg_q;
    if (sr_done && !overrun) begin
      // Covers both an empty buffer and one being drained this same cycle.
      push_val_d = 1'b1;
      push_msg_d = sr_word;
    end else if (push_drain) begin
      push_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      push_val_q <= 1'b0;
      push_msg_q <= '0;
    end else begin
      push_val_q <= push_val_d;
      push_msg_q <= push_msg_d;
    end
  end

  assign push_val = push_val_q;
  assign push_msg = push_msg_q;

`ifdef SPI_MINION_CTRL_STATUS_EN
  // ---------------------------------------------------------------------------
  // Status counters
  // ---------------------------------------------------------------------------
  logic [7:0] abort_cnt_q;
  logic [7:0] overrun_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      abort_cnt_q   <= '0;
      overrun_cnt_q <= '0;
    end else begin
      if (abort)   abort_cnt_q   <= sat_inc8(abort_cnt_q);
      if (overrun) overrun_cnt_q <= sat_inc8(overrun_cnt_q);
    end
  end

  assign abort_count   = abort_cnt_q;
  assign overrun_count = overrun_cnt_q;
`else
  // Event strobes only feed the optional status counters.
  logic unused_status;
  assign unused_status = abort ^ overrun;
`endif

endmodule
